// File: rtl/ex_operand_stage.sv
// ex_operand_stage
//   ID/EX pipeline register in front of the 64-bit LEGv8 ALU. It holds one
//   decoded instruction under a valid/ready handshake. Operands are forwarded
//   from EX/MEM and MEM/WB, and the stage supports stall and flush.
//
// Ports
//   clk, reset              rising-edge clock, async active-high reset
//   in_valid / in_ready     decode-side handshake
//   in_rd1, in_rd2, in_imm  register-file data and sign-extended immediate
//   in_alu_src, in_alu_ctl  operand-b select and ALU opcode
//   in_rn, in_rm, in_rd     register indices
//   in_reg_write            instruction writes rd
//   flush                   drop held and incoming instruction
//   exmem_*, memwb_*        forwarding sources (write enable, index, result)
//   out_valid / out_ready   ALU-side handshake
//   a, b, ALUcontrol        ALU operands and opcode
//   store_data              forwarded Rm/Rt for stores
//   out_rd, out_reg_write   destination passthrough (write gated by out_valid)
module ex_operand_stage #(
  parameter int N = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_rd1,
  input  logic [N-1:0] in_rd2,
  input  logic [N-1:0] in_imm,
  input  logic         in_alu_src,
  input  logic [3:0]   in_alu_ctl,
  input  logic [4:0]   in_rn,
  input  logic [4:0]   in_rm,
  input  logic [4:0]   in_rd,
  input  logic         in_reg_write,
  input  logic         flush,
  input  logic         exmem_reg_write,
  input  logic [4:0]   exmem_rd,
  input  logic [N-1:0] exmem_result,
  input  logic         memwb_reg_write,
  input  logic [4:0]   memwb_rd,
  input  logic [N-1:0] memwb_result,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] a,
  output logic [N-1:0] b,
  output logic [3:0]   ALUcontrol,
  output logic [N-1:0] store_data,
  output logic [4:0]   out_rd,
  output logic         out_reg_write
);

  localparam logic [4:0] XZR = 5'd31;

  logic         valid_q;
  logic [N-1:0] rd1_q;
  logic [N-1:0] rd2_q;
  logic [N-1:0] imm_q;
  logic         alu_src_q;
  logic [3:0]   alu_ctl_q;
  logic [4:0]   rn_q;
  logic [4:0]   rm_q;
  logic [4:0]   rd_q;
  logic         reg_write_q;
  logic         load;

  assign in_ready = ~valid_q | out_ready;
  assign load     = in_valid & in_ready & ~flush;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q     <= 1'b0;
      rd1_q       <= '0;
      rd2_q       <= '0;
      imm_q       <= '0;
      alu_src_q   <= 1'b0;
      alu_ctl_q   <= 4'b0000;
      rn_q        <= 5'd0;
      rm_q        <= 5'd0;
      rd_q        <= 5'd0;
      reg_write_q <= 1'b0;
    end else begin
      if (flush) begin
        valid_q <= 1'b0;
      end else if (load) begin
        valid_q <= 1'b1;
      end else if (valid_q & out_ready) begin
        valid_q <= 1'b0;
      end
      // Fields only move on a real load; flush and drain leave them stale.
      if (load) begin
        rd1_q       <= in_rd1;
        rd2_q       <= in_rd2;
        imm_q       <= in_imm;
        alu_src_q   <= in_alu_src;
        alu_ctl_q   <= in_alu_ctl;
        rn_q        <= in_rn;
        rm_q        <= in_rm;
        rd_q        <= in_rd;
        reg_write_q <= in_reg_write;
      end
    end
  end

  // Forwarding reads the held indices every cycle, so a stalled instruction
  // picks up results that arrive during the stall. EX/MEM is younger and wins.
  logic [N-1:0] fwd_rn;
  logic [N-1:0] fwd_rm;

  always_comb begin
    fwd_rn = rd1_q;
    if (exmem_reg_write && (exmem_rd == rn_q) && (rn_q != XZR)) begin
      fwd_rn = exmem_result;
    end else if (memwb_reg_write && (memwb_rd == rn_q) && (rn_q != XZR)) begin
      fwd_rn = memwb_result;
    end
  end

  always_comb begin
    fwd_rm = rd2_q;
    if (exmem_reg_write && (exmem_rd == rm_q) && (rm_q != XZR)) begin
      fwd_rm = exmem_result;
    end else if (memwb_reg_write && (memwb_rd == rm_q) && (rm_q != XZR)) begin
      fwd_rm = memwb_result;
    end
  end

  assign out_valid     = valid_q;
  assign a             = fwd_rn;
  assign store_data    = fwd_rm;
  assign b             = alu_src_q ? imm_q : fwd_rm;
  assign ALUcontrol    = alu_ctl_q;
  assign out_rd        = rd_q;
  assign out_reg_write = reg_write_q & valid_q;

endmodule

// File: tb/tb_ex_operand_stage.sv
module tb_ex_operand_stage;

  localparam int N = 64;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_rd1, in_rd2, in_imm;
  logic         in_alu_src;
  logic [3:0]   in_alu_ctl;
  logic [4:0]   in_rn, in_rm, in_rd;
  logic         in_reg_write;
  logic         flush;
  logic         exmem_reg_write;
  logic [4:0]   exmem_rd;
  logic [N-1:0] exmem_result;
  logic         memwb_reg_write;
  logic [4:0]   memwb_rd;
  logic [N-1:0] memwb_result;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] a, b, store_data;
  logic [3:0]   ALUcontrol;
  logic [4:0]   out_rd;
  logic         out_reg_write;

  int checks = 0;
  int errors = 0;

  ex_operand_stage #(.N(N)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rd1(in_rd1), .in_rd2(in_rd2), .in_imm(in_imm),
    .in_alu_src(in_alu_src), .in_alu_ctl(in_alu_ctl),
    .in_rn(in_rn), .in_rm(in_rm), .in_rd(in_rd),
    .in_reg_write(in_reg_write), .flush(flush),
    .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
    .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
    .out_valid(out_valid), .out_ready(out_ready),
    .a(a), .b(b), .ALUcontrol(ALUcontrol), .store_data(store_data),
    .out_rd(out_rd), .out_reg_write(out_reg_write)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  // Reference model: the instruction currently held (if any).
  typedef struct {
    logic [N-1:0] rd1, rd2, imm;
    logic         src;
    logic [3:0]   ctl;
    logic [4:0]   rn, rm, rd;
    logic         we;
  } instr_t;

  bit     m_valid;
  instr_t m_ins;

  function automatic instr_t zero_instr();
    instr_t z;
    z.rd1 = '0; z.rd2 = '0; z.imm = '0; z.src = 0; z.ctl = 0;
    z.rn = 0; z.rm = 0; z.rd = 0; z.we = 0;
    return z;
  endfunction

  // Value of register r as the ALU should see it: youngest in-flight writer
  // wins, X31 always reads the register-file value.
  function automatic logic [N-1:0] exp_src(input logic [4:0] r, input logic [N-1:0] rf);
    if (r == 5'd31) return rf;
    if (exmem_reg_write && exmem_rd == r) return exmem_result;
    if (memwb_reg_write && memwb_rd == r) return memwb_result;
    return rf;
  endfunction

  task automatic set_instr(input logic [N-1:0] rd1, input logic [N-1:0] rd2,
                           input logic [N-1:0] imm, input logic src, input logic [3:0] ctl,
                           input logic [4:0] rn, input logic [4:0] rm, input logic [4:0] rd,
                           input logic we);
    in_rd1 = rd1; in_rd2 = rd2; in_imm = imm; in_alu_src = src; in_alu_ctl = ctl;
    in_rn = rn; in_rm = rm; in_rd = rd; in_reg_write = we;
  endtask

  task automatic no_fwd();
    exmem_reg_write = 0; exmem_rd = 0; exmem_result = '0;
    memwb_reg_write = 0; memwb_rd = 0; memwb_result = '0;
  endtask

  // One clock edge; the model advances with the inputs seen just before it.
  task automatic step();
    instr_t nxt;
    bit take;
    take = in_valid && (!m_valid || out_ready) && !flush;
    nxt.rd1 = in_rd1; nxt.rd2 = in_rd2; nxt.imm = in_imm; nxt.src = in_alu_src;
    nxt.ctl = in_alu_ctl; nxt.rn = in_rn; nxt.rm = in_rm; nxt.rd = in_rd; nxt.we = in_reg_write;
    @(posedge clk);
    if (flush) m_valid = 0;
    else if (take) begin m_valid = 1; m_ins = nxt; end
    else if (m_valid && out_ready) m_valid = 0;
    #1;
  endtask

  task automatic test_reset();
    no_fwd();
    reset = 0; flush = 0; out_ready = 0; in_valid = 1;
    set_instr(64'h1234, 64'h5678, 64'h9, 1'b0, 4'b0110, 5'd1, 5'd2, 5'd3, 1'b1);
    step();
    checks++;
    if (out_valid !== 1'b1) begin
      errors++; $display("FAIL reset_preload out_valid got %b exp 1", out_valid);
    end
    in_valid = 0;
    #2 reset = 1;
    m_valid = 0; m_ins = zero_instr();
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_handshake out_valid %b in_ready %b exp 0 1", out_valid, in_ready);
    end
    checks++;
    if (a !== '0 || b !== '0 || store_data !== '0 || ALUcontrol !== 4'b0000) begin
      errors++; $display("FAIL reset_data a %h b %h sd %h ctl %h exp all 0", a, b, store_data, ALUcontrol);
    end
    checks++;
    if (out_rd !== 5'd0 || out_reg_write !== 1'b0) begin
      errors++; $display("FAIL reset_rd out_rd %0d we %b exp 0 0", out_rd, out_reg_write);
    end
    #3 reset = 0;
    #1;
  endtask

  task automatic test_plain();
    no_fwd(); flush = 0; out_ready = 1; in_valid = 1;
    set_instr(64'd5, 64'd7, 64'd0, 1'b0, 4'b0010, 5'd1, 5'd2, 5'd4, 1'b1);
    step();
    checks++;
    if (a !== 64'd5 || b !== 64'd7 || ALUcontrol !== 4'b0010 || out_valid !== 1'b1) begin
      errors++; $display("FAIL plain_reg a %0d b %0d ctl %b v %b exp 5 7 0010 1", a, b, ALUcontrol, out_valid);
    end
    checks++;
    if (out_rd !== 5'd4 || out_reg_write !== 1'b1) begin
      errors++; $display("FAIL plain_rd out_rd %0d we %b exp 4 1", out_rd, out_reg_write);
    end
    set_instr(64'd5, 64'd7, 64'd100, 1'b1, 4'b0010, 5'd1, 5'd2, 5'd4, 1'b0);
    step();
    checks++;
    if (b !== 64'd100 || store_data !== 64'd7) begin
      errors++; $display("FAIL plain_imm b %0d sd %0d exp 100 7", b, store_data);
    end
    checks++;
    if (out_reg_write !== 1'b0) begin
      errors++; $display("FAIL plain_nowrite we %b exp 0", out_reg_write);
    end
    in_valid = 0; step();
    checks++;
    if (out_valid !== 1'b0 || out_reg_write !== 1'b0) begin
      errors++; $display("FAIL plain_drain out_valid %b we %b exp 0 0", out_valid, out_reg_write);
    end
  endtask

  task automatic test_forward();
    no_fwd(); flush = 0; out_ready = 0; in_valid = 1;
    set_instr(64'h11, 64'h22, 64'h0, 1'b0, 4'b0001, 5'd3, 5'd6, 5'd7, 1'b1);
    step(); in_valid = 0;
    exmem_reg_write = 1; exmem_rd = 5'd3; exmem_result = 64'hAA;
    memwb_reg_write = 1; memwb_rd = 5'd3; memwb_result = 64'hBB;
    #1;
    checks++;
    if (a !== 64'hAA) begin errors++; $display("FAIL fwd_exmem_wins a %h exp aa", a); end
    exmem_reg_write = 0; #1;
    checks++;
    if (a !== 64'hBB) begin errors++; $display("FAIL fwd_memwb a %h exp bb", a); end
    memwb_reg_write = 0; #1;
    checks++;
    if (a !== 64'h11) begin errors++; $display("FAIL fwd_none a %h exp 11", a); end
    // Rm path: forwarded into b and store_data
    exmem_reg_write = 1; exmem_rd = 5'd6; exmem_result = 64'hCC; #1;
    checks++;
    if (b !== 64'hCC || store_data !== 64'hCC || a !== 64'h11) begin
      errors++; $display("FAIL fwd_rm b %h sd %h a %h exp cc cc 11", b, store_data, a);
    end
    no_fwd(); out_ready = 1; in_valid = 1;
    set_instr(64'h31, 64'h32, 64'h0, 1'b0, 4'b0001, 5'd31, 5'd31, 5'd7, 1'b1);
    step(); in_valid = 0; out_ready = 0;
    exmem_reg_write = 1; exmem_rd = 5'd31; exmem_result = 64'hAA;
    memwb_reg_write = 1; memwb_rd = 5'd31; memwb_result = 64'hBB;
    #1;
    checks++;
    if (a !== 64'h31 || b !== 64'h32) begin
      errors++; $display("FAIL fwd_xzr a %h b %h exp 31 32", a, b);
    end
    no_fwd(); out_ready = 1; step();
  endtask

  task automatic test_stall();
    no_fwd(); flush = 0; out_ready = 0; in_valid = 1;
    set_instr(64'h40, 64'h44, 64'h0, 1'b0, 4'b0101, 5'd8, 5'd4, 5'd9, 1'b1);
    step();
    set_instr(64'hDEAD, 64'hBEEF, 64'h1, 1'b1, 4'b1111, 5'd10, 5'd11, 5'd12, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || ALUcontrol !== 4'b0101 ||
          out_rd !== 5'd9 || a !== 64'h40 || b !== 64'h44) begin
        errors++;
        $display("FAIL stall_hold cyc %0d rdy %b v %b ctl %b rd %0d a %h b %h exp 0 1 0101 9 40 44",
                 i, in_ready, out_valid, ALUcontrol, out_rd, a, b);
      end
      step();
    end
    memwb_reg_write = 1; memwb_rd = 5'd4; memwb_result = 64'h55; #1;
    checks++;
    if (b !== 64'h55 || store_data !== 64'h55) begin
      errors++; $display("FAIL stall_late_fwd b %h sd %h exp 55 55", b, store_data);
    end
    no_fwd(); in_valid = 0; out_ready = 1; step();
  endtask

  task automatic test_back_to_back();
    no_fwd(); flush = 0; out_ready = 1; in_valid = 1;
    for (int k = 0; k < 4; k++) begin
      set_instr(64'(k), 64'(k + 10), 64'h0, 1'b0, 4'(k + 1), 5'd1, 5'd2, 5'(k), 1'b1);
      step();
      checks++;
      if (out_valid !== 1'b1 || ALUcontrol !== 4'(k + 1) || in_ready !== 1'b1 || a !== 64'(k)) begin
        errors++;
        $display("FAIL b2b_%0d v %b ctl %0d rdy %b a %0d exp 1 %0d 1 %0d",
                 k, out_valid, ALUcontrol, in_ready, a, k + 1, k);
      end
    end
    in_valid = 0; step();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain v %b exp 0", out_valid); end
  endtask

  task automatic test_flush();
    no_fwd(); flush = 0; out_ready = 0; in_valid = 1;
    set_instr(64'h70, 64'h71, 64'h0, 1'b0, 4'b0111, 5'd1, 5'd2, 5'd3, 1'b1);
    step();
    flush = 1;
    set_instr(64'h80, 64'h81, 64'h0, 1'b0, 4'b1000, 5'd4, 5'd5, 5'd6, 1'b1);
    step();
    checks++;
    if (out_valid !== 1'b0 || out_reg_write !== 1'b0) begin
      errors++; $display("FAIL flush_empty v %b we %b exp 0 0", out_valid, out_reg_write);
    end
    flush = 0; in_valid = 0; step();
    checks++;
    if (out_valid !== 1'b0 || ALUcontrol !== 4'b0111 || a !== 64'h70) begin
      errors++; $display("FAIL flush_not_captured v %b ctl %b a %h exp 0 0111 70", out_valid, ALUcontrol, a);
    end
  endtask

  function automatic logic [4:0] pick_reg();
    case ($urandom_range(0, 3))
      0: return m_ins.rn;
      1: return m_ins.rm;
      2: return 5'd31;
      default: return 5'($urandom_range(0, 31));
    endcase
  endfunction

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      in_valid = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 6);
      flush = ($urandom_range(0, 9) == 0);
      set_instr({$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
                1'($urandom), 4'($urandom), 5'($urandom_range(0, 31)),
                ($urandom_range(0, 4) == 0) ? 5'd31 : 5'($urandom_range(0, 31)),
                5'($urandom), 1'($urandom));
      exmem_reg_write = 1'($urandom); exmem_rd = pick_reg(); exmem_result = {$urandom, $urandom};
      memwb_reg_write = 1'($urandom); memwb_rd = pick_reg(); memwb_result = {$urandom, $urandom};
      #1;
      checks++;
      if (out_valid !== m_valid || in_ready !== (!m_valid || out_ready)) begin
        errors++;
        $display("FAIL rnd_handshake cyc %0d v %b rdy %b exp %b %b", i, out_valid, in_ready,
                 m_valid, (!m_valid || out_ready));
      end
      checks++;
      if (a !== exp_src(m_ins.rn, m_ins.rd1)) begin
        errors++; $display("FAIL rnd_a cyc %0d got %h exp %h", i, a, exp_src(m_ins.rn, m_ins.rd1));
      end
      checks++;
      if (store_data !== exp_src(m_ins.rm, m_ins.rd2) ||
          b !== (m_ins.src ? m_ins.imm : exp_src(m_ins.rm, m_ins.rd2))) begin
        errors++;
        $display("FAIL rnd_b cyc %0d b %h sd %h exp %h %h", i, b, store_data,
                 (m_ins.src ? m_ins.imm : exp_src(m_ins.rm, m_ins.rd2)), exp_src(m_ins.rm, m_ins.rd2));
      end
      checks++;
      if (ALUcontrol !== m_ins.ctl || out_rd !== m_ins.rd || out_reg_write !== (m_ins.we && m_valid)) begin
        errors++;
        $display("FAIL rnd_fields cyc %0d ctl %h rd %0d we %b exp %h %0d %b", i, ALUcontrol,
                 out_rd, out_reg_write, m_ins.ctl, m_ins.rd, (m_ins.we && m_valid));
      end
      step();
    end
  endtask

  initial begin
    reset = 1; in_valid = 0; out_ready = 0; flush = 0;
    set_instr('0, '0, '0, 1'b0, 4'd0, 5'd0, 5'd0, 5'd0, 1'b0);
    no_fwd();
    m_valid = 0; m_ins = zero_instr();
    #12 reset = 0;
    #1;
    test_reset();
    test_plain();
    test_forward();
    test_stall();
    test_back_to_back();
    test_flush();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ex_operand_stage.md
# ex_operand_stage

ID/EX pipeline stage for the 64-bit LEGv8 datapath; sits directly upstream of the ALU and drives its `a`, `b` and `ALUcontrol` inputs. It captures decoded operands under a valid/ready handshake. It resolves RAW hazards by forwarding results from the EX/MEM and MEM/WB stages, and supports stall and flush.

## Interface
- `N`, 64, datapath width
- `clk`  in  1  clock, all state updates on rising edge
- `reset`  in  1  asynchronous, active-high reset
- `in_valid`  in  1  decode stage presents an instruction
- `in_ready`  out  1  stage can accept this cycle
- `in_rd1`, `in_rd2`  in  N  register-file read data for Rn, Rm/Rt
- `in_imm`  in  N  sign-extended immediate
- `in_alu_src`  in  1  1: `b` takes immediate; 0: `b` takes forwarded Rm
- `in_alu_ctl`  in  4  ALU operation code
- `in_rn`, `in_rm`, `in_rd`  in  5  register indices
- `in_reg_write`  in  1  instruction writes `rd`
- `flush`  in  1  discard held and incoming instruction
- `exmem_reg_write`  in  1; `exmem_rd`  in  5; `exmem_result`  in  N  EX/MEM forward source
- `memwb_reg_write`  in  1; `memwb_rd`  in  5; `memwb_result`  in  N  MEM/WB forward source
- `out_valid`  out  1  held instruction valid
- `out_ready`  in  1  downstream consumes this cycle
- `a`, `b`  out  N  ALU operands
- `ALUcontrol`  out  4  ALU operation
- `store_data`  out  N  forwarded Rm/Rt for stores
- `out_rd`  out  5; `out_reg_write`  out  1  passthrough of held fields, `out_reg_write` gated by `out_valid`

## Operation
- One-entry pipeline register holding rd1, rd2, imm, alu_src, alu_ctl, rn, rm, rd, reg_write, valid.
- `in_ready = ~out_valid | out_ready`. Load occurs when `in_valid & in_ready & ~flush`.
- Register update priority:
  1. `flush`: valid := 0.
  2. Load: all fields := inputs, valid := 1.
  3. `out_valid & out_ready` without load: valid := 0.
  4. Otherwise hold, i.e. stall with fields unchanged.
- Forwarding is combinational on the held fields and evaluated every cycle, so a stalled instruction picks up results that arrive while stalled. For each source register `r` (rn, rm), in this order:
  - If `exmem_reg_write & exmem_rd == r & r != 31`, use `exmem_result`.
  - Else if `memwb_reg_write & memwb_rd == r & r != 31`, use `memwb_result`.
  - Else use the held register-file value.
  - EX/MEM always beats MEM/WB.
- X31 (XZR) is never forwarded.
- `a` = forwarded Rn.
- `store_data` = forwarded Rm.
- `b` = `alu_src ? imm : store_data`.
- `ALUcontrol` = held alu_ctl.
- Outputs are meaningful only while `out_valid`. When invalid, values reflect the stale held fields; the consumer ignores them.
- No arithmetic is performed in this stage; widths pass through unchanged.

## Timing
- Reset (async assert): valid=0 and all held fields = 0. Resulting outputs:
  - `out_valid=0`, `in_ready=1`
  - `a=b=store_data=0`, `ALUcontrol=4'b0000`
  - `out_rd=0`, `out_reg_write=0`
- Latency: an instruction accepted at edge k is presented to the ALU from edge k through the edge at which it is consumed.
- Throughput: 1 per cycle when `out_ready` is held at 1.
- Simultaneous consume and accept at the same edge: the new instruction replaces the old one with no bubble.
- `flush` has priority over `in_valid` and over stall; the stage is empty after the edge.
- `out_ready=0` while `out_valid=1`: `in_ready=0` and the held fields remain stable.
- Reset deasserted mid-stream: the first accepted instruction is the one presented at the first rising edge after deassertion.

## Test plan
- Reset: assert `reset` mid-cycle with `out_valid=1` -> outputs go to zero immediately (`out_valid=0`, `ALUcontrol=0`, `a=b=0`) without waiting for a clock edge.
- Plain pass: rd1=5, rd2=7, alu_src=0, alu_ctl=0010, rn=1, rm=2, no forwards -> after one edge `a=5`, `b=7`, `ALUcontrol=0010`, `out_valid=1`. With alu_src=1, imm=100 -> `b=100`, `store_data=7`.
- Forward priority: rn=3, exmem (rd=3, result=0xAA, we=1), memwb (rd=3, result=0xBB, we=1) -> `a=0xAA`. With exmem_we=0 -> `a=0xBB`. With rn=31 and both forwards targeting rd=31 -> `a` = held rd1.
- Stall and late forward: `out_ready=0` for 3 cycles -> `in_ready=0` and held fields unchanged. memwb_rd=rm with result 0x55 arrives during the stall -> `b=0x55` that same cycle.
- Back-to-back: `out_ready=1`, 4 consecutive valid instructions -> 4 consecutive cycles of `out_valid=1` with matching `ALUcontrol` sequence and no bubbles.
- Flush: `flush=1` with `in_valid=1` while the stage holds a valid instruction -> `out_valid=0` after the edge and the incoming instruction is not captured.
